// File: rtl/secure_frv_masked_barith_sched.sv
// rtl/secure_frv_masked_barith_sched.sv - two-requester scheduler for a masked adder with fresh-randomness fetch and watchdog
// Optional SECURE_BARITH_SCHED_CLEAR_EN adds a CLR state that wipes operands/randomness after every response.
module secure_frv_masked_barith_sched #(
    parameter int WDOG_CYCLES = 31,
    parameter int W           = 32
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             flush,

    input  logic             req0_valid,
    input  logic             req0_sub,
    input  logic [4*W-1:0]   req0_opnd,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_sub,
    input  logic [4*W-1:0]   req1_opnd,
    output logic             req1_ready,

    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic             resp_err,
    output logic [2*W-1:0]   resp_res,

    output logic             rng_req,
    input  logic             rng_ack,
    input  logic [2*W-1:0]   rng_data,

    output logic             u_ena,
    output logic             u_flush,
    output logic             u_sub,
    output logic [2*W-1:0]   u_gs,
    output logic [4*W-1:0]   u_opnd,
    input  logic [2*W-1:0]   u_res,
    input  logic             u_rdy,

    output logic             busy
);

    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RNG  = 3'd1,
        S_RUN  = 3'd2,
        S_RESP = 3'd3
`ifdef SECURE_BARITH_SCHED_CLEAR_EN
        ,
        S_CLR  = 3'd4
`endif
    } state_t;

    state_t           state;
    logic             ptr;
    logic             cur_id;
    logic             sub_q;
    logic [4*W-1:0]   opnd_q;
    logic [2*W-1:0]   gs_q;
    logic [2*W-1:0]   res_q;
    logic             err_q;
    logic             resp0_q;
    logic             resp1_q;
    logic             rng_req_q;
    logic             u_ena_q;
    logic             u_flush_q;
    logic [7:0]       wdog;

    logic             gnt_any;
    logic             gnt_id;
    logic             accept;

    // Round-robin: the pointer's requester wins if valid, otherwise the other one.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = ptr;
        if (ptr ? !req1_valid : !req0_valid) begin
            gnt_id = ~ptr;
        end
    end

    assign accept     = (state == S_IDLE) && !flush && !g_reset && gnt_any;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept &&  gnt_id;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state     <= S_IDLE;
            ptr       <= 1'b0;
            cur_id    <= 1'b0;
            sub_q     <= 1'b0;
            opnd_q    <= '0;
            gs_q      <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            resp0_q   <= 1'b0;
            resp1_q   <= 1'b0;
            rng_req_q <= 1'b0;
            u_ena_q   <= 1'b0;
            u_flush_q <= 1'b0;
            wdog      <= 8'd0;
        end else begin
            u_flush_q <= 1'b0;
            resp0_q   <= 1'b0;
            resp1_q   <= 1'b0;
            res_q     <= '0;
            err_q     <= 1'b0;
            if (flush) begin
                // Abort wins over everything, including a same-cycle u_rdy.
                state     <= S_IDLE;
                u_flush_q <= 1'b1;
                rng_req_q <= 1'b0;
                u_ena_q   <= 1'b0;
                sub_q     <= 1'b0;
                opnd_q    <= '0;
                gs_q      <= '0;
                wdog      <= 8'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (gnt_any) begin
                            cur_id    <= gnt_id;
                            sub_q     <= gnt_id ? req1_sub  : req0_sub;
                            opnd_q    <= gnt_id ? req1_opnd : req0_opnd;
                            rng_req_q <= 1'b1;
                            state     <= S_RNG;
                        end
                    end
                    S_RNG: begin
                        if (rng_ack) begin
                            gs_q      <= rng_data;
                            rng_req_q <= 1'b0;
                            u_ena_q   <= 1'b1;
                            wdog      <= 8'd0;
                            state     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (u_rdy) begin
                            u_ena_q <= 1'b0;
                            res_q   <= u_res;
                            resp0_q <= !cur_id;
                            resp1_q <=  cur_id;
                            state   <= S_RESP;
                        end else if (wdog == WDOG_LAST) begin
                            u_ena_q   <= 1'b0;
                            u_flush_q <= 1'b1;
                            err_q     <= 1'b1;
                            resp0_q   <= !cur_id;
                            resp1_q   <=  cur_id;
                            state     <= S_RESP;
                        end else begin
                            wdog <= wdog + 8'd1;
                        end
                    end
                    S_RESP: begin
                        ptr  <= ~cur_id;
                        wdog <= 8'd0;
`ifdef SECURE_BARITH_SCHED_CLEAR_EN
                        sub_q  <= 1'b0;
                        opnd_q <= '0;
                        gs_q   <= '0;
                        state  <= S_CLR;
`else
                        state  <= S_IDLE;
`endif
                    end
`ifdef SECURE_BARITH_SCHED_CLEAR_EN
                    S_CLR: begin
                        state <= S_IDLE;
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign resp0_valid = resp0_q;
    assign resp1_valid = resp1_q;
    assign resp_err    = err_q;
    assign resp_res    = res_q;
    assign rng_req     = rng_req_q;
    assign u_ena       = u_ena_q;
    assign u_flush     = u_flush_q;
    assign u_sub       = sub_q;
    assign u_gs        = gs_q;
    assign u_opnd      = opnd_q;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_secure_frv_masked_barith_sched.sv
// tb/tb_secure_frv_masked_barith_sched.sv - scoreboard bench for secure_frv_masked_barith_sched
module tb_secure_frv_masked_barith_sched;

    localparam int W    = 32;
    localparam int WDOG = 31;

    logic           g_clk = 1'b0;
    logic           g_reset = 1'b1;
    logic           flush = 1'b0;
    logic           req0_valid = 1'b0, req0_sub = 1'b0;
    logic           req1_valid = 1'b0, req1_sub = 1'b0;
    logic [4*W-1:0] req0_opnd = '0, req1_opnd = '0;
    logic           req0_ready, req1_ready;
    logic           resp0_valid, resp1_valid, resp_err;
    logic [2*W-1:0] resp_res;
    logic           rng_req;
    logic           rng_ack = 1'b0;
    logic [2*W-1:0] rng_data = '0;
    logic           u_ena, u_flush, u_sub;
    logic [2*W-1:0] u_gs;
    logic [4*W-1:0] u_opnd;
    logic [2*W-1:0] u_res = '0;
    logic           u_rdy = 1'b0;
    logic           busy;

    secure_frv_masked_barith_sched #(.WDOG_CYCLES(WDOG), .W(W)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .req0_valid(req0_valid), .req0_sub(req0_sub), .req0_opnd(req0_opnd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sub(req1_sub), .req1_opnd(req1_opnd), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_err(resp_err), .resp_res(resp_res),
        .rng_req(rng_req), .rng_ack(rng_ack), .rng_data(rng_data),
        .u_ena(u_ena), .u_flush(u_flush), .u_sub(u_sub), .u_gs(u_gs), .u_opnd(u_opnd),
        .u_res(u_res), .u_rdy(u_rdy), .busy(busy)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic           id;
        logic           err;
        logic [2*W-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    logic gnt_log[$];
    int   checks = 0, failures = 0;
    int   rem[2], rdy_cnt[2];
    int   rng_used = 0, rng_lat = 2, rng_wait = 0;
    int   add_lat = 11, add_wait = 0;
    bit   add_hang = 1'b0;
    int   ena_run = 0, last_ena_len = 0, flush_cnt = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [2*W-1:0] gs_word(input int k);
        return {32'hC3A5_0000 ^ 32'(k * 7 + 1), 32'h5A00_0000 + 32'(k * 13 + 3)};
    endfunction

    // Reference for the external masked adder: any fixed mixing of operands, randomness and sub works.
    function automatic logic [2*W-1:0] add_model(input logic [4*W-1:0] op, input logic [2*W-1:0] gs, input logic sub);
        return {op[127:96] ^ op[95:64] ^ gs[63:32] ^ {32{sub}}, op[31:0] + op[63:32] + gs[31:0]};
    endfunction

    // Randomness source: acks after rng_lat cycles of rng_req, one fresh word per consumption.
    initial forever begin
        @(posedge g_clk);
        if (rng_ack && !flush && !g_reset) rng_used++;
        #1;
        rng_ack  = 1'b0;
        rng_data = '0;
        if (rng_req) begin
            rng_wait++;
            if (rng_wait >= rng_lat) begin
                rng_ack  = 1'b1;
                rng_data = gs_word(rng_used);
                rng_wait = 0;
            end
        end else begin
            rng_wait = 0;
        end
    end

    // Masked adder stand-in: u_rdy on the add_lat-th cycle of u_ena.
    initial forever begin
        @(posedge g_clk);
        #1;
        u_rdy = 1'b0;
        u_res = '0;
        if (u_ena && !add_hang) begin
            add_wait++;
            if (add_wait >= add_lat) begin
                u_rdy    = 1'b1;
                u_res    = add_model(u_opnd, u_gs, u_sub);
                add_wait = 0;
            end
        end else begin
            add_wait = 0;
        end
    end

    // Accept watcher: push the expected response when a ready is seen.
    initial forever begin
        logic           id;
        logic [4*W-1:0] op;
        logic           sb;
        exp_t           e;
        @(negedge g_clk);
        if (!g_reset && (req0_ready || req1_ready)) begin
            check_eq("ready_onehot", req0_ready & req1_ready, 0);
            id = req1_ready;
            rdy_cnt[id]++;
            gnt_log.push_back(id);
            op = id ? req1_opnd : req0_opnd;
            sb = id ? req1_sub  : req0_sub;
            e.id  = id;
            e.err = add_hang;
            e.res = add_hang ? '0 : add_model(op, gs_word(rng_used), sb);
            exp_q.push_back(e);
            @(posedge g_clk);
            #1;
            rem[id]--;
            if (rem[id] <= 0) begin
                if (id) req1_valid = 1'b0;
                else    req0_valid = 1'b0;
            end
        end
    end

    // Response monitor and u_ena/u_flush bookkeeping.
    initial forever begin
        exp_t e;
        @(negedge g_clk);
        if (g_reset) begin
            ena_run = 0;
        end else begin
            if (u_flush) flush_cnt++;
            if (u_ena) ena_run++;
            else if (ena_run > 0) begin
                last_ena_len = ena_run;
                ena_run      = 0;
            end
            if (resp0_valid || resp1_valid) begin
                check_eq("resp_onehot", resp0_valid & resp1_valid, 0);
                if (exp_q.size() == 0) begin
                    check_eq("resp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("resp_id", resp1_valid, e.id);
                    check_eq("resp_err", resp_err, e.err);
                    check_eq("resp_res", resp_res, e.res);
                end
            end else begin
                check_eq("res_zero_idle", {resp_res, resp_err}, 0);
            end
        end
    end

    task automatic do_reset();
        g_reset    = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        g_reset = 1'b0;
    endtask

    task automatic start_req(input int r0, input int r1);
        @(posedge g_clk);
        #1;
        rem[0] = r0;
        rem[1] = r1;
        if (r0 > 0) req0_valid = 1'b1;
        if (r1 > 0) req1_valid = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge g_clk);
            n++;
        end while ((busy || req0_valid || req1_valid || exp_q.size() != 0) && n < 2000);
        check_eq(tag, n >= 2000, 0);
        @(negedge g_clk);
    endtask

    initial begin
        int             n;
        logic [4*W-1:0] hold_op;

        @(negedge g_clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ctrl", {rng_req, u_ena, u_flush, u_sub, resp0_valid, resp1_valid, resp_err}, 0);
        check_eq("rst_u_opnd", u_opnd, 0);
        check_eq("rst_u_gs", u_gs, 0);
        check_eq("rst_res", resp_res, 0);
        do_reset();

        // Single op on req0, rng after 2, adder after 11.
        req0_opnd  = {32'd0, 32'd0, 32'd5, 32'd3};
        req0_sub   = 1'b0;
        rdy_cnt[0] = 0;
        rdy_cnt[1] = 0;
        flush_cnt  = 0;
        start_req(1, 0);
        wait_idle("a_timeout");
        check_eq("a_ready0", rdy_cnt[0], 1);
        check_eq("a_ready1", rdy_cnt[1], 0);
        check_eq("a_ena_len", last_ena_len, 11);
        check_eq("a_no_uflush", flush_cnt, 0);

        // Both requesters from reset: order req0, req1, req0.
        do_reset();
        gnt_log.delete();
        add_lat   = 3;
        req0_opnd = {$urandom, $urandom, $urandom, $urandom};
        req1_opnd = {$urandom, $urandom, $urandom, $urandom};
        req0_sub  = 1'b1;
        req1_sub  = 1'b0;
        start_req(2, 1);
        wait_idle("b_timeout");
        check_eq("b_grants", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            check_eq("b_gnt0", gnt_log[0], 0);
            check_eq("b_gnt1", gnt_log[1], 1);
            check_eq("b_gnt2", gnt_log[2], 0);
        end

        // Watchdog: adder never finishes.
        add_hang  = 1'b1;
        flush_cnt = 0;
        req1_opnd = {$urandom, $urandom, $urandom, $urandom};
        start_req(0, 1);
        wait_idle("c_timeout");
        check_eq("c_uflush_cnt", flush_cnt, 1);
        check_eq("c_ena_len", last_ena_len, WDOG);

        // Flush at RUN cycle 4; pointer (now req0) must stay put.
        flush_cnt = 0;
        req0_opnd = {$urandom, $urandom, $urandom, $urandom};
        start_req(1, 0);
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge g_clk);
            if (u_ena) n++;
        end
        check_eq("d_run4", n, 4);
        flush = 1'b1;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge g_clk);
        check_eq("d_busy", busy, 0);
        check_eq("d_uflush", u_flush, 1);
        check_eq("d_ena_rng", {u_ena, rng_req}, 0);
        check_eq("d_opnd_clr", u_opnd, 0);
        check_eq("d_gs_clr", u_gs, 0);
        add_hang = 1'b0;
        gnt_log.delete();
        start_req(1, 1);
        wait_idle("d_timeout");
        check_eq("d_uflush_cnt", flush_cnt, 1);
        check_eq("d_ptr_kept", (gnt_log.size() > 0) ? gnt_log[0] : 1'bx, 0);

        // Operand visibility after an op completes.
        hold_op   = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        req1_opnd = hold_op;
        start_req(0, 1);
        wait_idle("e_timeout");
`ifdef SECURE_BARITH_SCHED_CLEAR_EN
        check_eq("e_opnd_cleared", u_opnd, 0);
        check_eq("e_gs_cleared", u_gs, 0);
`else
        check_eq("e_opnd_held", u_opnd, hold_op);
        check_eq("e_gs_held", u_gs, gs_word(rng_used - 1));
`endif

        // Reset during RNG with pointer at req1: next grant goes to req0.
        req0_opnd = {$urandom, $urandom, $urandom, $urandom};
        start_req(1, 0);
        wait_idle("f_pre_timeout");
        rng_lat = 6;
        start_req(1, 0);
        n = 0;
        while (!rng_req && n < 50) begin
            @(negedge g_clk);
            n++;
        end
        check_eq("f_in_rng", rng_req, 1);
        g_reset = 1'b1;
        #1;
        check_eq("f_rng_drop", rng_req, 0);
        check_eq("f_busy_drop", busy, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge g_clk);
        #1;
        g_reset = 1'b0;
        rng_lat = 2;
        gnt_log.delete();
        start_req(1, 1);
        wait_idle("f_timeout");
        check_eq("f_gnt_req0", (gnt_log.size() > 0) ? gnt_log[0] : 1'bx, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
